// File: rtl/pe_mac_lane_node_if.sv
// pe_mac_lane_node_if
//   Bundles the config bus, operand stream, child result streams, parent
//   link and status of one PE tree node.
//   master : the environment side (drives config, operands, child data,
//            parent ready)
//   slave  : the PE node side (drives in_ready, ch_ready, parent link, busy)
interface pe_mac_lane_node_if #(
  parameter int NOC_WID  = 16,
  parameter int LANES    = 2,
  parameter int N_CHILD  = 2,
  parameter int ADDR_WID = 11
);
  logic                           cfg_we;
  logic [ADDR_WID-1:0]            cfg_adr;
  logic [NOC_WID-1:0]             cfg_dat;
  logic [ADDR_WID-1:0]            slv_addr;
  logic                           in_valid;
  logic                           in_ready;
  logic [LANES*NOC_WID-1:0]       in_data;
  logic [N_CHILD-1:0]             ch_valid;
  logic [N_CHILD-1:0]             ch_ready;
  logic [N_CHILD*2*NOC_WID-1:0]   ch_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [2*NOC_WID-1:0]           out_data;
  logic                           busy;

  modport master (
    output cfg_we, cfg_adr, cfg_dat, slv_addr,
    output in_valid, in_data,
    output ch_valid, ch_data,
    output out_ready,
    input  in_ready, ch_ready, out_valid, out_data, busy
  );

  modport slave (
    input  cfg_we, cfg_adr, cfg_dat, slv_addr,
    input  in_valid, in_data,
    input  ch_valid, ch_data,
    input  out_ready,
    output in_ready, ch_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/pe_mac_lane_node.sv
// pe_mac_lane_node
//   Tree-node PE: LANES-wide signed dot-product MAC with a small config
//   register window, plus a round-robin merge of N_CHILD child result
//   streams and the local result onto the parent link.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : pe_mac_lane_node_if.slave (config, operands, child streams,
//          parent link, busy)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | disabled, no operands accepted
//   ST_ACC   | accepting operand beats, accumulating
//   ST_DRAIN | saturated result waiting for the parent-link arbiter
module pe_mac_lane_node #(
  parameter int NOC_WID  = 16,
  parameter int LANES    = 2,
  parameter int N_CHILD  = 2,
  parameter int ADDR_WID = 11,
  parameter int ACC_WID  = 40
) (
  input logic                clk,
  input logic                rstn,
  pe_mac_lane_node_if.slave  bus
);

  localparam int RES_WID = 2 * NOC_WID;
  localparam int N_SRC   = N_CHILD + 1;
  localparam int PTR_WID = $clog2(N_SRC);
  localparam int OFF_WID = ADDR_WID + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // ---------------- config window ----------------
  logic [OFF_WID-1:0]        adr_x, base_x, lim_x, off;
  logic                      cfg_hit;
  logic                      en_q, clr_q;
  logic [NOC_WID-1:0]        len_q;
  logic signed [NOC_WID-1:0] wgt_q [LANES];

  // One extra bit so a window near the top of the address space never
  // wraps around onto low addresses.
  assign adr_x   = {1'b0, bus.cfg_adr};
  assign base_x  = {1'b0, bus.slv_addr};
  assign lim_x   = base_x + OFF_WID'(2 + LANES);
  assign off     = adr_x - base_x;
  assign cfg_hit = bus.cfg_we && (adr_x >= base_x) && (adr_x < lim_x);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
      len_q <= '0;
      for (int k = 0; k < LANES; k++) wgt_q[k] <= '0;
    end else begin
      clr_q <= 1'b0;
      if (cfg_hit) begin
        if (off == OFF_WID'(0)) begin
          en_q  <= bus.cfg_dat[0];
          clr_q <= bus.cfg_dat[1];
        end else if (off == OFF_WID'(1)) begin
          len_q <= bus.cfg_dat;
        end else begin
          for (int k = 0; k < LANES; k++)
            if (off == OFF_WID'(2 + k)) wgt_q[k] <= bus.cfg_dat;
        end
      end
    end
  end

  // ---------------- MAC datapath ----------------
  logic [1:0]                state_q;
  logic signed [ACC_WID-1:0] acc_q, beat_sum, acc_sum;
  logic signed [RES_WID-1:0] prod;
  logic [NOC_WID-1:0]        cnt_q, len_eff;
  logic [RES_WID-1:0]        res_q, res_sat;
  logic [ACC_WID-RES_WID:0]  acc_top;
  logic                      in_ready, beat_acc, last_beat, res_valid;
  logic                      local_gnt;

  always_comb begin
    beat_sum = '0;
    prod     = '0;
    for (int k = 0; k < LANES; k++) begin
      prod     = wgt_q[k] * $signed(bus.in_data[k*NOC_WID +: NOC_WID]);
      beat_sum = beat_sum + ACC_WID'(prod);
    end
  end

  assign acc_sum = acc_q + beat_sum;

  // Saturate when the bits above the result sign are not a pure sign extension.
  assign acc_top = acc_sum[ACC_WID-1:RES_WID-1];
  always_comb begin
    if (&acc_top || ~|acc_top)
      res_sat = acc_sum[RES_WID-1:0];
    else if (acc_sum[ACC_WID-1])
      res_sat = {1'b1, {(RES_WID-1){1'b0}}};
    else
      res_sat = {1'b0, {(RES_WID-1){1'b1}}};
  end

  assign len_eff   = (len_q == '0) ? NOC_WID'(1) : len_q;
  assign last_beat = (cnt_q == len_eff - NOC_WID'(1));
  assign in_ready  = (state_q == ST_ACC);
  assign beat_acc  = bus.in_valid && in_ready;
  assign res_valid = (state_q == ST_DRAIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_q) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ST_ACC: begin
          // CLR wins over everything, including a beat taken this cycle.
          if (clr_q) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (!en_q) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else if (beat_acc) begin
            if (last_beat) begin
              res_q   <= res_sat;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_DRAIN;
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + NOC_WID'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (local_gnt) state_q <= en_q ? ST_ACC : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------- parent-link arbiter ----------------
  logic                 run_q;
  logic                 out_valid_q, load, gnt_found;
  logic [RES_WID-1:0]   out_data_q;
  logic [PTR_WID-1:0]   ptr_q, gnt_idx, scan_idx;
  logic [N_SRC-1:0]     req;
  logic [RES_WID-1:0]   src_data [N_SRC];
  logic [N_CHILD-1:0]   ch_ready;

  // Held low for the first cycle after reset so ch_ready stays quiet while
  // rstn is asserted, without gating combinational outputs on rstn itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  assign load = run_q && (!out_valid_q || bus.out_ready);
  assign req  = {res_valid, bus.ch_valid};

  always_comb begin
    for (int i = 0; i < N_CHILD; i++) src_data[i] = bus.ch_data[i*RES_WID +: RES_WID];
    src_data[N_CHILD] = res_q;
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      scan_idx = PTR_WID'((int'(ptr_q) + i) % N_SRC);
      if (!gnt_found && req[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CHILD; i++)
      ch_ready[i] = load && gnt_found && (gnt_idx == PTR_WID'(i));
  end

  assign local_gnt = load && gnt_found && (gnt_idx == PTR_WID'(N_CHILD));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      if (gnt_found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= src_data[gnt_idx];
        ptr_q       <= (gnt_idx == PTR_WID'(N_SRC - 1)) ? '0 : gnt_idx + PTR_WID'(1);
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ch_ready  = ch_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_mac_lane_node.sv
module tb_pe_mac_lane_node;
  localparam int NOC_WID  = 16;
  localparam int LANES    = 2;
  localparam int N_CHILD  = 2;
  localparam int ADDR_WID = 11;
  localparam int ACC_WID  = 40;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pe_mac_lane_node_if #(.NOC_WID(NOC_WID), .LANES(LANES), .N_CHILD(N_CHILD),
                        .ADDR_WID(ADDR_WID)) bus ();

  pe_mac_lane_node #(.NOC_WID(NOC_WID), .LANES(LANES), .N_CHILD(N_CHILD),
                     .ADDR_WID(ADDR_WID), .ACC_WID(ACC_WID)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_out_cyc = 0;

  logic [31:0] exp_q [$];
  logic [31:0] in_q  [$];
  logic [31:0] ch0_q [$];
  logic [31:0] ch1_q [$];

  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [31:0] beat(input int l0, input int l1);
    return {l1[15:0], l0[15:0]};
  endfunction

  function automatic int pending();
    return exp_q.size() + in_q.size() + ch0_q.size() + ch1_q.size();
  endfunction

  task automatic drive_inputs();
    bus.in_valid      = (in_q.size() > 0);
    bus.in_data       = (in_q.size() > 0) ? in_q[0] : '0;
    bus.ch_valid[0]   = (ch0_q.size() > 0);
    bus.ch_data[31:0] = (ch0_q.size() > 0) ? ch0_q[0] : '0;
    bus.ch_valid[1]   = (ch1_q.size() > 0);
    bus.ch_data[63:32] = (ch1_q.size() > 0) ? ch1_q[0] : '0;
  endtask

  // One clock: sample mid-cycle, let the edge happen, then advance sources.
  task automatic step();
    logic              in_acc;
    logic [N_CHILD-1:0] ch_acc;
    logic [31:0]       want;
    @(negedge clk);
    if (hold_prev) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(bus.out_data), 64'(hold_data));
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    hold_data = bus.out_data;
    if (hold_prev) chk("stall_ch_ready", 64'(bus.ch_ready), 64'd0);
    if (bus.out_valid && bus.out_ready) begin
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("out_extra", 64'(bus.out_valid), 64'd0);
      end else begin
        want = exp_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(want));
      end
    end
    in_acc = bus.in_valid && bus.in_ready;
    ch_acc = bus.ch_valid & bus.ch_ready;
    if (in_acc) last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (in_acc) void'(in_q.pop_front());
    if (ch_acc[0]) void'(ch0_q.pop_front());
    if (ch_acc[1]) void'(ch1_q.pop_front());
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    if (pending() != 0) chk("timeout_pending", 64'(pending()), 64'd0);
  endtask

  task automatic cfg_raw(input logic [ADDR_WID-1:0] adr, input logic [15:0] dat);
    bus.cfg_we  = 1'b1;
    bus.cfg_adr = adr;
    bus.cfg_dat = dat;
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic cfg_write(input int off, input logic [15:0] dat);
    cfg_raw(bus.slv_addr + ADDR_WID'(off), dat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn          = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_adr   = '0;
    bus.cfg_dat   = '0;
    bus.slv_addr  = 11'h100;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ch_valid  = '0;
    bus.ch_data   = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_ch_ready", 64'(bus.ch_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rstn = 1'b1;
    step();

    // single-beat result, W={3,-2}, LEN=1
    cfg_write(2, 16'd3);
    cfg_write(3, 16'hFFFE);
    cfg_write(1, 16'd1);
    cfg_write(0, 16'h0001);
    in_q.push_back(beat(5, 4));
    exp_q.push_back(32'd7);
    drive_inputs();
    run_until_done(30);
    chk("latency", 64'(last_out_cyc - last_acc_cyc), 64'd2);
    chk("back_acc_busy", 64'(bus.busy), 64'd1);
    chk("back_acc_in_ready", 64'(bus.in_ready), 64'd1);

    // round-robin merge with a mid-stream stall
    bus.out_ready = 1'b0;
    in_q.push_back(beat(5, 4));
    exp_q.push_back(32'd7);
    drive_inputs();
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      ch0_q.push_back(32'hA000_0000 + 32'(i));
      ch1_q.push_back(32'hB000_0000 + 32'(i));
      exp_q.push_back(32'hA000_0000 + 32'(i));
      exp_q.push_back(32'hB000_0000 + 32'(i));
      if (i < 3) begin
        in_q.push_back(beat(11 + i, 1));
        exp_q.push_back(32'(28 + 3 * (i + 1)));
      end
    end
    drive_inputs();
    repeat (3) step();
    for (int n = 0; n < 80 && pending() != 0; n++) begin
      bus.out_ready = !(n >= 4 && n < 9);
      step();
    end
    bus.out_ready = 1'b1;
    chk("rr_pending", 64'(pending()), 64'd0);

    // multi-beat result, no early output
    cfg_write(2, 16'd1);
    cfg_write(3, 16'd1);
    cfg_write(1, 16'd3);
    in_q.push_back(beat(1, 2));
    in_q.push_back(beat(3, 4));
    drive_inputs();
    run_until_done(20);
    repeat (4) step();
    chk("no_early_out", 64'(bus.out_valid), 64'd0);
    in_q.push_back(beat(5, 6));
    exp_q.push_back(32'd21);
    drive_inputs();
    run_until_done(20);

    // positive and negative saturation
    cfg_write(2, 16'd32767);
    cfg_write(3, 16'd32767);
    cfg_write(1, 16'd4);
    for (int i = 0; i < 4; i++) in_q.push_back(beat(32767, 32767));
    exp_q.push_back(32'h7FFF_FFFF);
    drive_inputs();
    run_until_done(30);
    cfg_write(2, 16'h8000);
    cfg_write(3, 16'h8000);
    for (int i = 0; i < 4; i++) in_q.push_back(beat(32767, 32767));
    exp_q.push_back(32'h8000_0000);
    drive_inputs();
    run_until_done(30);

    // EN cleared mid-result drops the partial sum
    cfg_write(2, 16'd1);
    cfg_write(3, 16'd1);
    in_q.push_back(beat(1, 1));
    in_q.push_back(beat(2, 2));
    drive_inputs();
    run_until_done(20);
    cfg_write(0, 16'h0000);
    repeat (3) step();
    chk("en_off_busy", 64'(bus.busy), 64'd0);
    chk("en_off_out_valid", 64'(bus.out_valid), 64'd0);
    cfg_write(0, 16'h0001);
    for (int i = 0; i < 4; i++) in_q.push_back(beat(1, 0));
    exp_q.push_back(32'd4);
    drive_inputs();
    run_until_done(30);

    // CLR restarts the count; the beat taken in the CLR cycle is discarded
    in_q.push_back(beat(100, 0));
    in_q.push_back(beat(100, 0));
    drive_inputs();
    run_until_done(20);
    cfg_write(0, 16'h0003);
    in_q.push_back(beat(50, 0));
    for (int i = 0; i < 4; i++) in_q.push_back(beat(1, 0));
    exp_q.push_back(32'd4);
    drive_inputs();
    run_until_done(30);

    // window at the top of the address space must not wrap onto low addresses
    bus.slv_addr = 11'h7FE;
    cfg_raw(11'h000, 16'd100);
    cfg_raw(11'h001, 16'd100);
    bus.slv_addr = 11'h100;
    cfg_write(1, 16'd1);
    in_q.push_back(beat(2, 3));
    exp_q.push_back(32'd5);
    // LEN=0 behaves as LEN=1
    drive_inputs();
    run_until_done(20);
    cfg_write(1, 16'd0);
    in_q.push_back(beat(4, 4));
    in_q.push_back(beat(1, 1));
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd2);
    drive_inputs();
    run_until_done(30);

    // reset while a result sits in DRAIN behind a stalled parent link
    bus.out_ready = 1'b0;
    in_q.push_back(beat(1, 1));
    in_q.push_back(beat(1, 1));
    drive_inputs();
    run_until_done(20);
    repeat (3) step();
    chk("drain_busy", 64'(bus.busy), 64'd1);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd1);
    rstn = 1'b0;
    hold_prev = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_ch_ready", 64'(bus.ch_ready), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) step();
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
